// File: rtl/link_arbiter.sv
// Two-requester round-robin arbiter driving one frame at a time over an RTS/CTS link,
// with per-phase timeouts, a fixed two-cycle backoff and a bounded number of retries.
module link_arbiter #(
  parameter int FW        = 66,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [0:FW-1] data0,
  input  logic [0:FW-1] data1,
  output logic          grant0,
  output logic          grant1,
  output logic          done0,
  output logic          done1,
  output logic          fail0,
  output logic          fail1,
  output logic          link_rts,
  input  logic          link_cts,
  output logic [0:FW-1] link_out,
  output logic          busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BOFF_LAST = CNT_W'(1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    BACKOFF = 3'd3,
    DONE    = 3'd4,
    FAIL    = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RTY_W-1:0]   rty, rty_nxt;
  logic               sel, sel_nxt;
  logic               ptr, ptr_nxt;
  logic [0:FW-1]      frame, frame_nxt;
  logic               win;
  logic [RTY_W-1:0]   rty_up;
  logic               exhausted;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_LAST) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RTY_W-1:0] rty_inc(input logic [RTY_W-1:0] v);
    return (v == RTY_MAX) ? v : v + RTY_W'(1);
  endfunction

  // Control state is reset; the latched frame is only ever visible when not IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rty   <= '0;
      sel   <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rty   <= rty_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    frame <= frame_nxt;
  end

  // ptr names the requester that wins a tie
  assign win       = (req0 && req1) ? ptr : req1;
  assign rty_up    = rty_inc(rty);
  assign exhausted = (rty_up == RTY_MAX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rty_nxt   = rty;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    frame_nxt = frame;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          sel_nxt   = win;
          frame_nxt = win ? data1 : data0;
          cnt_nxt   = '0;
          rty_nxt   = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (link_cts) begin
          cnt_nxt   = '0;
          state_nxt = XFER;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          rty_nxt   = rty_up;
          state_nxt = exhausted ? FAIL : BACKOFF;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      XFER: begin
        // Receiver signals acceptance by releasing CTS
        if (!link_cts) begin
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          rty_nxt   = rty_up;
          state_nxt = exhausted ? FAIL : BACKOFF;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      BACKOFF: begin
        if (cnt == BOFF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = REQ;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      DONE, FAIL: begin
        ptr_nxt   = ~sel;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    grant0   = busy && !sel;
    grant1   = busy && sel;
    link_rts = (state == REQ) || (state == XFER);
    done0    = (state == DONE) && !sel;
    done1    = (state == DONE) && sel;
    fail0    = (state == FAIL) && !sel;
    fail1    = (state == FAIL) && sel;
    link_out = '0;
    if ((state == REQ) || (state == XFER) || (state == BACKOFF))
      link_out = frame;
  end

endmodule

// File: tb/tb_link_arbiter.sv
// Randomized bench for link_arbiter: a scripted receiver answers RTS, and a transaction-level
// model predicts winner, outcome, busy duration and the frame seen on the link.
module tb_link_arbiter;

  localparam int FW  = 66;
  localparam int TMO = 16;
  localparam int MR  = 3;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [0:FW-1] data0 = '0, data1 = '0;
  logic          grant0, grant1, done0, done1, fail0, fail1;
  logic          link_rts, busy;
  logic          link_cts = 1'b0;
  logic [0:FW-1] link_out;

  link_arbiter #(.FW(FW), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .fail0(fail0), .fail1(fail1), .link_rts(link_rts), .link_cts(link_cts),
    .link_out(link_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // receiver script per attempt: CTS rises d cycles into RTS, stays high h more cycles
  int d_arr[MR];
  int h_arr[MR];
  int last_served = 1;

  int obs_busy, obs_g0, obs_g1, obs_gboth, obs_d0, obs_d1, obs_f0, obs_f1;
  logic [0:FW-1] obs_and, obs_or;
  int rts_runs[$];

  function automatic logic [0:FW-1] rnd_frame();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[FW-1:0];
  endfunction

  function automatic void set_script(input int d, input int h);
    for (int k = 0; k < MR; k++) begin
      d_arr[k] = d;
      h_arr[k] = h;
    end
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return (last_served == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  // busy cycles = attempt lengths + 2 per backoff + the final DONE/FAIL cycle
  function automatic int model_cycles(output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b0;
    for (int k = 0; k < MR; k++) begin
      if (d_arr[k] >= TMO) cyc += TMO;
      else if (h_arr[k] >= TMO) cyc += d_arr[k] + 1 + TMO;
      else begin
        cyc += d_arr[k] + 1 + h_arr[k] + 1;
        ok = 1'b1;
        return cyc + 1;
      end
      if (k == MR - 1) return cyc + 1;
      cyc += 2;
    end
    return cyc + 1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
  task automatic drive_txn(input bit r0, input bit r1, input logic [0:FW-1] f0, input logic [0:FW-1] f1);
    int run, att, idx, i;
    bit ended;
    req0 = r0; req1 = r1; data0 = f0; data1 = f1; link_cts = 1'b0;
    obs_busy = 0; obs_g0 = 0; obs_g1 = 0; obs_gboth = 0;
    obs_d0 = 0; obs_d1 = 0; obs_f0 = 0; obs_f1 = 0;
    obs_and = '1; obs_or = '0;
    rts_runs.delete();
    run = 0; att = 0; ended = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      obs_busy++;
      if (grant0) obs_g0++;
      if (grant1) obs_g1++;
      if (grant0 && grant1) obs_gboth++;
      if (done0) obs_d0++;
      if (done1) obs_d1++;
      if (fail0) obs_f0++;
      if (fail1) obs_f1++;
      if (!(done0 || done1 || fail0 || fail1)) begin
        obs_and &= link_out;
        obs_or  |= link_out;
      end
      if (link_rts) run++;
      else if (run > 0) begin
        rts_runs.push_back(run);
        run = 0;
        att++;
      end
      idx = (att < MR) ? att : MR - 1;
      i = run - 1;
      link_cts = link_rts && (i >= d_arr[idx]) && (i <= d_arr[idx] + h_arr[idx]);
      req0 = 1'($urandom); req1 = 1'($urandom);
      data0 = rnd_frame(); data1 = rnd_frame();
    end
    if (run > 0) rts_runs.push_back(run);
    if (!ended) obs_busy = -1;
    req0 = 1'b0; req1 = 1'b0; link_cts = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; link_cts = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_served = 1;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    apply_reset();
    outs = {grant0, grant1, done0, done1, fail0, fail1, link_rts, busy, |link_out, 1'b0};
    n_cmp++;
    if (outs !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=0", outs);
    end
  endtask

  task automatic test_single();
    logic [0:FW-1] f;
    int exp_cyc;
    bit ok;
    f = 66'h2_AAAA_5555_0F0F_F0F0;
    set_script(3, 1);
    exp_cyc = model_cycles(ok);
    drive_txn(1'b1, 1'b0, f, rnd_frame());
    n_cmp++;
    if (obs_busy !== exp_cyc) begin n_bad++; $display("FAIL single_busy got=%0d want=%0d", obs_busy, exp_cyc); end
    n_cmp++;
    if ((obs_and !== f) || (obs_or !== f)) begin n_bad++; $display("FAIL single_frame got=%h/%h want=%h", obs_and, obs_or, f); end
    n_cmp++;
    if ({obs_d0, obs_f0, obs_d1, obs_f1} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_bad++; $display("FAIL single_pulses got d0=%0d f0=%0d d1=%0d f1=%0d want d0=1", obs_d0, obs_f0, obs_d1, obs_f1);
    end
    n_cmp++;
    if ((obs_g0 !== exp_cyc) || (obs_g1 !== 0)) begin n_bad++; $display("FAIL single_grant got g0=%0d g1=%0d want g0=%0d g1=0", obs_g0, obs_g1, exp_cyc); end
    n_cmp++;
    if ({grant0, link_rts, busy, |link_out} !== 4'b0) begin n_bad++; $display("FAIL single_idle_after got=%b want=0000", {grant0, link_rts, busy, |link_out}); end
    last_served = 0;
  endtask

  task automatic test_alternate();
    int win;
    apply_reset();
    set_script(0, 0);
    for (int k = 0; k < 6; k++) begin
      win = pick(1'b1, 1'b1);
      drive_txn(1'b1, 1'b1, rnd_frame(), rnd_frame());
      n_cmp++;
      if (((win == 0) && (obs_g0 == 0 || obs_g1 != 0 || obs_d0 != 1)) ||
          ((win == 1) && (obs_g1 == 0 || obs_g0 != 0 || obs_d1 != 1))) begin
        n_bad++;
        $display("FAIL alternate_%0d got g0=%0d g1=%0d d0=%0d d1=%0d want winner=%0d", k, obs_g0, obs_g1, obs_d0, obs_d1, win);
      end
      n_cmp++;
      if (obs_busy !== 3) begin n_bad++; $display("FAIL alternate_busy_%0d got=%0d want=3", k, obs_busy); end
      last_served = win;
    end
  endtask

  task automatic test_req_timeout();
    int exp_cyc;
    bit ok;
    set_script(TMO + 5, 0);
    exp_cyc = model_cycles(ok);
    drive_txn(1'b1, 1'b0, rnd_frame(), rnd_frame());
    n_cmp++;
    if (obs_busy !== exp_cyc) begin n_bad++; $display("FAIL reqto_busy got=%0d want=%0d", obs_busy, exp_cyc); end
    n_cmp++;
    if ((rts_runs.size() != MR) || (rts_runs[0] != TMO) || (rts_runs[MR-1] != TMO)) begin
      n_bad++; $display("FAIL reqto_windows got n=%0d first=%0d want n=%0d len=%0d", rts_runs.size(), (rts_runs.size() > 0) ? rts_runs[0] : -1, MR, TMO);
    end
    n_cmp++;
    if ({obs_f0, obs_d0} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL reqto_pulse got f0=%0d d0=%0d want f0=1 d0=0", obs_f0, obs_d0); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reqto_busy_drop got=%b want=0", busy); end
    last_served = 0;
  endtask

  task automatic test_xfer_stuck();
    int exp_cyc;
    bit ok;
    set_script(2, 1000);
    exp_cyc = model_cycles(ok);
    drive_txn(1'b0, 1'b1, rnd_frame(), rnd_frame());
    n_cmp++;
    if (obs_busy !== exp_cyc) begin n_bad++; $display("FAIL stuck_busy got=%0d want=%0d", obs_busy, exp_cyc); end
    n_cmp++;
    if ((rts_runs.size() != MR) || (rts_runs[1] != 3 + TMO)) begin
      n_bad++; $display("FAIL stuck_windows got n=%0d want n=%0d len=%0d", rts_runs.size(), MR, 3 + TMO);
    end
    n_cmp++;
    if ({obs_f1, obs_d1, obs_g0} !== {32'd1, 32'd0, 32'd0}) begin n_bad++; $display("FAIL stuck_pulse got f1=%0d d1=%0d g0=%0d want 1/0/0", obs_f1, obs_d1, obs_g0); end
    last_served = 1;
  endtask

  task automatic test_reset_mid();
    logic [0:FW-1] f;
    bit ok;
    int exp_cyc;
    f = rnd_frame();
    req0 = 1'b1; data0 = f;
    @(posedge clk); @(negedge clk);
    link_cts = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ((link_rts !== 1'b1) || (link_out !== f)) begin n_bad++; $display("FAIL midrst_xfer got rts=%b out=%h want rts=1 out=%h", link_rts, link_out, f); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({grant0, grant1, done0, done1, fail0, fail1, link_rts, busy, |link_out} !== 9'b0) begin
      n_bad++; $display("FAIL midrst_outputs got=%b want=0", {grant0, grant1, done0, done1, fail0, fail1, link_rts, busy, |link_out});
    end
    req0 = 1'b0; link_cts = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({done0, fail0} !== 2'b0) begin n_bad++; $display("FAIL midrst_nopulse got=%b want=00", {done0, fail0}); end
    rst_n = 1'b1;
    last_served = 1;
    set_script(1, 2);
    exp_cyc = model_cycles(ok);
    f = rnd_frame();
    drive_txn(1'b1, 1'b0, f, rnd_frame());
    n_cmp++;
    if ((obs_busy !== exp_cyc) || (obs_d0 !== 1) || (obs_and !== f)) begin
      n_bad++; $display("FAIL midrst_after got busy=%0d d0=%0d frame=%h want busy=%0d d0=1 frame=%h", obs_busy, obs_d0, obs_and, exp_cyc, f);
    end
    last_served = 0;
  endtask

  task automatic test_idle_cts();
    int bad;
    bad = 0;
    link_cts = 1'b1;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (busy || link_rts || grant0 || grant1) bad++;
    end
    link_cts = 1'b0;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL idle_cts got active_cycles=%0d want=0", bad); end
  endtask

  task automatic test_random();
    bit r0, r1, ok;
    int win, exp_cyc, gw, gl, pw, pf, other;
    logic [0:FW-1] f0, f1, fe;
    for (int t = 0; t < 40; t++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      for (int k = 0; k < MR; k++) begin
        d_arr[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 4);
        h_arr[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 4);
      end
      win = pick(r0, r1);
      exp_cyc = model_cycles(ok);
      f0 = rnd_frame(); f1 = rnd_frame();
      fe = win ? f1 : f0;
      drive_txn(r0, r1, f0, f1);
      gw = win ? obs_g1 : obs_g0;
      gl = win ? obs_g0 : obs_g1;
      pw = win ? (ok ? obs_d1 : obs_f1) : (ok ? obs_d0 : obs_f0);
      other = obs_d0 + obs_d1 + obs_f0 + obs_f1 - pw;
      n_cmp++;
      if (obs_busy !== exp_cyc) begin n_bad++; $display("FAIL rand%0d_busy got=%0d want=%0d", t, obs_busy, exp_cyc); end
      n_cmp++;
      if ((gw !== exp_cyc) || (gl !== 0) || (obs_gboth !== 0)) begin
        n_bad++; $display("FAIL rand%0d_grant got win=%0d lose=%0d both=%0d want win=%0d lose=0", t, gw, gl, obs_gboth, exp_cyc);
      end
      n_cmp++;
      if ((pw !== 1) || (other !== 0)) begin n_bad++; $display("FAIL rand%0d_pulse got=%0d other=%0d want=1/0 ok=%0d", t, pw, other, ok); end
      n_cmp++;
      if ((obs_and !== fe) || (obs_or !== fe)) begin n_bad++; $display("FAIL rand%0d_frame got=%h/%h want=%h", t, obs_and, obs_or, fe); end
      last_served = win;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_req_timeout();
    test_xfer_stuck();
    test_idle_cts();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
